// File: rtl/bus_pkg.sv
// bus_pkg: bus widths, region map, read-target select type and the address decoder.
package bus_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 128;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int FETCH_WIDTH = 4;
  localparam int SIZE_WIDTH = 2;
  localparam logic [ADDR_WIDTH-1:0] TCM_ADDR = 32'h8000_0000;
  localparam logic [ADDR_WIDTH-1:0] TCM_SIZE = 32'h0001_0000;
  localparam logic [ADDR_WIDTH-1:0] CLINT_ADDR = 32'h0200_0000;
  localparam logic [ADDR_WIDTH-1:0] CLINT_SIZE = 32'h0001_0000;
  typedef enum logic [1:0] {SEL_NONE, SEL_TCM, SEL_CLINT} sel_t;
  // The wrapped offset is only below size when addr sits inside [base, base+size).
  function automatic logic in_region(input logic [ADDR_WIDTH-1:0] addr, base, size);
    return addr >= base && (addr - base) < size;
  endfunction
  function automatic sel_t decode(input logic [ADDR_WIDTH-1:0] addr);
    return in_region(addr, TCM_ADDR, TCM_SIZE) ? SEL_TCM :
           in_region(addr, CLINT_ADDR, CLINT_SIZE) ? SEL_CLINT : SEL_NONE;
  endfunction
endpackage

// File: rtl/bus.sv
// bus: decodes fetch/stbuf requests onto TCM and CLINT, returns 1-cycle acks and read data.
// Ports: fetch master (addr/req -> data/ack), stbuf master (read+write addr/size/req, wdata ->
// rdata/acks), TCM fetch port, TCM data port, CLINT data port; clk, async active-high rst.
module bus
  import bus_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [ADDR_WIDTH-1:0]                      fetch_bus_addr,
  input  logic                                       fetch_bus_read_req,
  output logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0]   bus_fetch_data,
  output logic                                       bus_fetch_read_ack,
  input  logic [ADDR_WIDTH-1:0]                      stbuf_bus_read_addr,
  input  logic [ADDR_WIDTH-1:0]                      stbuf_bus_write_addr,
  input  logic [SIZE_WIDTH-1:0]                      stbuf_bus_read_size,
  input  logic [SIZE_WIDTH-1:0]                      stbuf_bus_write_size,
  input  logic [REG_DATA_WIDTH-1:0]                  stbuf_bus_data,
  input  logic                                       stbuf_bus_read_req,
  input  logic                                       stbuf_bus_write_req,
  output logic [REG_DATA_WIDTH-1:0]                  bus_stbuf_data,
  output logic                                       bus_stbuf_read_ack,
  output logic                                       bus_stbuf_write_ack,
  output logic [ADDR_WIDTH-1:0]                      bus_tcm_fetch_addr,
  output logic                                       bus_tcm_fetch_rd,
  input  logic [BUS_DATA_WIDTH-1:0]                  tcm_bus_fetch_data,
  output logic [ADDR_WIDTH-1:0]                      bus_tcm_stbuf_read_addr,
  output logic [ADDR_WIDTH-1:0]                      bus_tcm_stbuf_write_addr,
  output logic [SIZE_WIDTH-1:0]                      bus_tcm_stbuf_read_size,
  output logic [SIZE_WIDTH-1:0]                      bus_tcm_stbuf_write_size,
  output logic [REG_DATA_WIDTH-1:0]                  bus_tcm_stbuf_data,
  output logic                                       bus_tcm_stbuf_rd,
  output logic                                       bus_tcm_stbuf_wr,
  input  logic [BUS_DATA_WIDTH-1:0]                  tcm_bus_stbuf_data,
  output logic [ADDR_WIDTH-1:0]                      bus_clint_read_addr,
  output logic [ADDR_WIDTH-1:0]                      bus_clint_write_addr,
  output logic [SIZE_WIDTH-1:0]                      bus_clint_read_size,
  output logic [SIZE_WIDTH-1:0]                      bus_clint_write_size,
  output logic [REG_DATA_WIDTH-1:0]                  bus_clint_data,
  output logic                                       bus_clint_rd,
  output logic                                       bus_clint_wr,
  input  logic [BUS_DATA_WIDTH-1:0]                  clint_bus_data
);
  sel_t w_fetch_sel, w_rd_sel, w_wr_sel, r_fetch_sel, r_stbuf_sel;
  logic r_fetch_ack, r_rd_ack, r_wr_ack;
  logic w_unused;
  assign w_fetch_sel = decode(fetch_bus_addr);
  assign w_rd_sel = decode(stbuf_bus_read_addr);
  assign w_wr_sel = decode(stbuf_bus_write_addr);
  assign bus_tcm_fetch_addr = fetch_bus_addr - TCM_ADDR;
  assign bus_tcm_fetch_rd = fetch_bus_read_req && w_fetch_sel == SEL_TCM;
  assign bus_tcm_stbuf_read_addr = stbuf_bus_read_addr - TCM_ADDR;
  assign bus_tcm_stbuf_write_addr = stbuf_bus_write_addr - TCM_ADDR;
  assign bus_tcm_stbuf_read_size = stbuf_bus_read_size;
  assign bus_tcm_stbuf_write_size = stbuf_bus_write_size;
  assign bus_tcm_stbuf_data = stbuf_bus_data;
  assign bus_tcm_stbuf_rd = stbuf_bus_read_req && w_rd_sel == SEL_TCM;
  assign bus_tcm_stbuf_wr = stbuf_bus_write_req && w_wr_sel == SEL_TCM;
  assign bus_clint_read_addr = stbuf_bus_read_addr - CLINT_ADDR;
  assign bus_clint_write_addr = stbuf_bus_write_addr - CLINT_ADDR;
  assign bus_clint_read_size = stbuf_bus_read_size;
  assign bus_clint_write_size = stbuf_bus_write_size;
  assign bus_clint_data = stbuf_bus_data;
  assign bus_clint_rd = stbuf_bus_read_req && w_rd_sel == SEL_CLINT;
  assign bus_clint_wr = stbuf_bus_write_req && w_wr_sel == SEL_CLINT;
  // Selects fall back to none without a request so idle cycles return zero data.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fetch_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      r_wr_ack <= 1'b0;
      r_fetch_sel <= SEL_NONE;
      r_stbuf_sel <= SEL_NONE;
    end else begin
      r_fetch_ack <= fetch_bus_read_req;
      r_rd_ack <= stbuf_bus_read_req;
      r_wr_ack <= stbuf_bus_write_req;
      r_fetch_sel <= fetch_bus_read_req ? w_fetch_sel : SEL_NONE;
      r_stbuf_sel <= stbuf_bus_read_req ? w_rd_sel : SEL_NONE;
    end
  assign bus_fetch_read_ack = r_fetch_ack;
  assign bus_stbuf_read_ack = r_rd_ack;
  assign bus_stbuf_write_ack = r_wr_ack;
  assign bus_fetch_data = r_fetch_sel == SEL_TCM ? tcm_bus_fetch_data : '0;
  assign bus_stbuf_data = r_stbuf_sel == SEL_TCM ? tcm_bus_stbuf_data[REG_DATA_WIDTH-1:0] :
                          r_stbuf_sel == SEL_CLINT ? clint_bus_data[REG_DATA_WIDTH-1:0] : '0;
  assign w_unused = ^{tcm_bus_stbuf_data[BUS_DATA_WIDTH-1:REG_DATA_WIDTH],
                      clint_bus_data[BUS_DATA_WIDTH-1:REG_DATA_WIDTH]};
endmodule

// File: tb/tb_bus.sv
// tb_bus: table-driven vectors with a response scoreboard, plus reset and async-reset sequences.
module tb_bus;
  logic clk = 0, rst = 1;
  logic [31:0] fa, ra, wa, wd;
  logic freq, rreq, wreq;
  logic [1:0] rs, ws;
  logic [127:0] tf, ts, cd;
  logic [127:0] fdata;
  logic [31:0] sdata, tfa, tra, twa, cra, cwa, tdata, cdata;
  logic fack, rack, wack, tf_rd, t_rd, t_wr, c_rd, c_wr;
  logic [1:0] trs, tws, crs, cws;
  int tests = 0, fails = 0;
  localparam logic [127:0] TF = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
  localparam logic [127:0] TS = 128'hacae_dffe_1ac1_d2e5_1205_abcd_fedd_1698;
  localparam logic [127:0] CD = 128'h1111_2222_3333_4444_5555_6666_bbcc_aadd;
  typedef struct {
    logic [31:0] fa; logic freq;
    logic [31:0] ra; logic rreq; logic [1:0] rs;
    logic [31:0] wa; logic wreq; logic [1:0] ws;
    logic [4:0] stb;
    logic [31:0] tfa, tra, twa, cra, cwa;
    logic efd; logic [31:0] esd;
  } vec_t;
  typedef struct {logic fack, rack, wack; logic [127:0] fdata; logic [31:0] sdata;} resp_t;
  vec_t v[6];
  resp_t q[$];
  resp_t r;
  always #5 clk = ~clk;
  bus dut (
    .clk(clk), .rst(rst),
    .fetch_bus_addr(fa), .fetch_bus_read_req(freq), .bus_fetch_data(fdata), .bus_fetch_read_ack(fack),
    .stbuf_bus_read_addr(ra), .stbuf_bus_write_addr(wa), .stbuf_bus_read_size(rs),
    .stbuf_bus_write_size(ws), .stbuf_bus_data(wd), .stbuf_bus_read_req(rreq),
    .stbuf_bus_write_req(wreq), .bus_stbuf_data(sdata), .bus_stbuf_read_ack(rack),
    .bus_stbuf_write_ack(wack),
    .bus_tcm_fetch_addr(tfa), .bus_tcm_fetch_rd(tf_rd), .tcm_bus_fetch_data(tf),
    .bus_tcm_stbuf_read_addr(tra), .bus_tcm_stbuf_write_addr(twa), .bus_tcm_stbuf_read_size(trs),
    .bus_tcm_stbuf_write_size(tws), .bus_tcm_stbuf_data(tdata), .bus_tcm_stbuf_rd(t_rd),
    .bus_tcm_stbuf_wr(t_wr), .tcm_bus_stbuf_data(ts),
    .bus_clint_read_addr(cra), .bus_clint_write_addr(cwa), .bus_clint_read_size(crs),
    .bus_clint_write_size(cws), .bus_clint_data(cdata), .bus_clint_rd(c_rd), .bus_clint_wr(c_wr),
    .clint_bus_data(cd)
  );
  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    fa = x.fa; freq = x.freq; ra = x.ra; rreq = x.rreq; rs = x.rs;
    wa = x.wa; wreq = x.wreq; ws = x.ws;
  endtask
  initial begin
    fa = '0; ra = '0; wa = '0; freq = 0; rreq = 0; wreq = 0; rs = '0; ws = '0;
    wd = 32'hdeadbeef; tf = TF; ts = TS; cd = CD;
    v[0] = '{32'h8000_0010, 1'b1, 32'h8000_0020, 1'b1, 2'b01, 32'h8000_0030, 1'b1, 2'b10, 5'b11100,
             32'h10, 32'h20, 32'h30, 32'h7e00_0020, 32'h7e00_0030, 1'b1, 32'hfedd1698};
    v[1] = '{32'h0, 1'b0, 32'h0200_0040, 1'b1, 2'b01, 32'h0200_0050, 1'b1, 2'b10, 5'b00011,
             32'h8000_0000, 32'h8200_0040, 32'h8200_0050, 32'h40, 32'h50, 1'b0, 32'hbbccaadd};
    v[2] = '{32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 2'b00, 32'h0, 1'b0, 2'b00, 5'b00000,
             32'h8000_1000, 32'h8000_1000, 32'h8000_0000, 32'hfe00_1000, 32'hfe00_0000, 1'b0, 32'h0};
    v[3] = '{32'h8000_fffc, 1'b1, 32'h8000_fffc, 1'b1, 2'b11, 32'h8001_0000, 1'b1, 2'b01, 5'b11000,
             32'hfffc, 32'hfffc, 32'h0001_0000, 32'h7e00_fffc, 32'h7e01_0000, 1'b1, 32'hfedd1698};
    v[4] = '{32'h0, 1'b0, 32'h0201_0000, 1'b1, 2'b10, 32'h0200_fffc, 1'b1, 2'b11, 5'b00001,
             32'h8000_0000, 32'h8201_0000, 32'h8200_fffc, 32'h0001_0000, 32'h0000_fffc, 1'b0, 32'h0};
    v[5] = '{32'h8000_0000, 1'b1, 32'h7fff_fffc, 1'b1, 2'b01, 32'h01ff_fffc, 1'b1, 2'b10, 5'b10000,
             32'h0, 32'hffff_fffc, 32'h81ff_fffc, 32'h7dff_fffc, 32'hffff_fffc, 1'b1, 32'h0};
    @(posedge clk);
    #1 rst = 0;
    #1;
    check("reset_acks", {fack, rack, wack}, 3'b000);
    check("reset_strobes", {tf_rd, t_rd, t_wr, c_rd, c_wr}, 5'b00000);
    check("reset_fdata", fdata, 128'h0);
    check("reset_sdata", sdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      check($sformatf("v%0d_strobes", i), {tf_rd, t_rd, t_wr, c_rd, c_wr}, v[i].stb);
      check($sformatf("v%0d_tcm_addrs", i), {tfa, tra, twa}, {v[i].tfa, v[i].tra, v[i].twa});
      check($sformatf("v%0d_clint_addrs", i), {cra, cwa}, {v[i].cra, v[i].cwa});
      check($sformatf("v%0d_pass", i), {trs, tws, crs, cws, tdata, cdata},
            {v[i].rs, v[i].ws, v[i].rs, v[i].ws, 32'hdeadbeef, 32'hdeadbeef});
      q.push_back('{v[i].freq, v[i].rreq, v[i].wreq, v[i].efd ? TF : 128'h0, v[i].esd});
      @(posedge clk);
      #1;
      if (q.size() == 0) check($sformatf("v%0d_queue", i), 0, 1);
      else begin
        r = q.pop_front();
        check($sformatf("v%0d_acks", i), {fack, rack, wack}, {r.fack, r.rack, r.wack});
        check($sformatf("v%0d_fdata", i), fdata, r.fdata);
        check($sformatf("v%0d_sdata", i), sdata, r.sdata);
      end
    end
    check("queue_drained", q.size(), 0);
    @(negedge clk);
    drive(v[0]);
    @(posedge clk);
    #1;
    check("pre_async_acks", {fack, rack, wack}, 3'b111);
    check("pre_async_sdata", sdata, 32'hfedd1698);
    #2 rst = 1;
    #1;
    check("async_acks", {fack, rack, wack}, 3'b000);
    check("async_data", {fdata, sdata}, 160'h0);
    check("async_comb_strobes", {tf_rd, t_rd, t_wr, c_rd, c_wr}, 5'b11100);
    @(negedge clk);
    rst = 0;
    drive(v[1]);
    @(posedge clk);
    #1;
    check("post_reset_acks", {fack, rack, wack}, 3'b011);
    check("post_reset_sdata", sdata, 32'hbbccaadd);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
